// File: rtl/rename_unit.sv
// Register-rename stage: maps 32 architectural registers onto 64 physical tags using a
// speculative map table, a free bitmap and an availability vector, with commit and flush recovery.
module rename_unit (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        FLUSH,
   input  logic        dec_valid,
   input  logic [4:0]  dec_srcA,
   input  logic [4:0]  dec_srcB,
   input  logic [4:0]  dec_dst,
   input  logic        dec_wr,
   output logic        ren_stall,
   output logic        ren_valid,
   output logic [5:0]  ren_mapA,
   output logic [5:0]  ren_mapB,
   output logic [5:0]  ren_mapWr,
   output logic [5:0]  ren_oldWr,
   output logic [63:0] busy,
   input  logic        wb_valid,
   input  logic [5:0]  wb_map,
   input  logic        commit_valid,
   input  logic [4:0]  commit_arch,
   input  logic [5:0]  commit_map,
   input  logic [5:0]  commit_old
);

   logic [5:0]  spec_rat [32];
   logic [5:0]  ret_rat [32];
   logic [5:0]  ret_rat_next [32];
   logic [63:0] free;
   logic [63:0] ret_used;
   logic [63:0] ret_used_next;
   logic [63:0] free_rel;
   logic [63:0] alloc_mask;
   logic [63:0] wb_set;
   logic [5:0]  alloc_tag;
   logic        alloc_req;
   logic        accept;
   logic        do_alloc;

   // Lowest-index free register wins; descending scan leaves the smallest index last.
   always_comb begin
      alloc_tag = '0;
      for (int i = 63; i >= 0; i--) begin
         if (free[i]) alloc_tag = 6'(i);
      end
   end

   assign alloc_req = dec_valid & dec_wr & (dec_dst != 5'd0);
   assign ren_stall = alloc_req & ~(|free);
   assign accept    = dec_valid & ~STALL & ~FLUSH & ~ren_stall;
   assign do_alloc  = accept & alloc_req;

   // Commit results are computed here so a same-cycle flush restores post-commit state.
   always_comb begin
      ret_rat_next  = ret_rat;
      ret_used_next = ret_used;
      free_rel      = '0;
      alloc_mask    = '0;
      wb_set        = '0;
      if (commit_valid) begin
         ret_rat_next[commit_arch] = commit_map;
         ret_used_next[commit_map] = 1'b1;
         ret_used_next[commit_old] = 1'b0;
         if (commit_old != 6'd0) free_rel[commit_old] = 1'b1;
      end
      if (do_alloc) alloc_mask[alloc_tag] = 1'b1;
      if (wb_valid && (wb_map != 6'd0)) wb_set[wb_map] = 1'b1;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < 32; i++) begin
            spec_rat[i] <= 6'(i);
            ret_rat[i]  <= 6'(i);
         end
         free     <= {32'hFFFF_FFFF, 32'h0000_0000};
         ret_used <= {32'h0000_0000, 32'hFFFF_FFFF};
         busy     <= '1;
      end else begin
         ret_rat  <= ret_rat_next;
         ret_used <= ret_used_next;
         if (FLUSH) begin
            spec_rat <= ret_rat_next;
            free     <= ~ret_used_next & ~64'd1;
            busy     <= '1;
         end else begin
            free <= (free & ~alloc_mask) | free_rel;
            busy <= (busy | wb_set) & ~alloc_mask;
            if (do_alloc) spec_rat[dec_dst] <= alloc_tag;
         end
      end
   end

   // Sources are read from the map before this instruction's own destination update.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ren_valid <= 1'b0;
         ren_mapA  <= '0;
         ren_mapB  <= '0;
         ren_mapWr <= '0;
         ren_oldWr <= '0;
      end else if (FLUSH) begin
         ren_valid <= 1'b0;
      end else if (!STALL) begin
         ren_valid <= accept;
         if (accept) begin
            ren_mapA  <= spec_rat[dec_srcA];
            ren_mapB  <= spec_rat[dec_srcB];
            ren_mapWr <= do_alloc ? alloc_tag : 6'd0;
            ren_oldWr <= do_alloc ? spec_rat[dec_dst] : 6'd0;
         end
      end
   end

endmodule
